// File: rtl/redpi_dac_ctrl.sv
// redpi_dac_ctrl: two-channel DAC playback sequencer with lockstep FIFOs, priming, bursts and underrun stats
module redpi_dac_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int PRIME_LEVEL   = 4,
    parameter int OFFSET_BINARY = 0
) (
    input  logic                          dac_clk_1x,
    input  logic                          dac_rstn,
    input  logic                          ctrl_start,
    input  logic                          ctrl_stop,
    input  logic [31:0]                   ctrl_burst_len,
    input  logic [15:0]                   a_tdata,
    input  logic                          a_tvalid,
    output logic                          a_tready,
    input  logic [15:0]                   b_tdata,
    input  logic                          b_tvalid,
    output logic                          b_tready,
    output logic [15:0]                   dac_da,
    output logic [15:0]                   dac_db,
    output logic                          stat_running,
    output logic                          stat_done,
    output logic [15:0]                   stat_underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   stat_a_level,
    output logic [$clog2(FIFO_DEPTH):0]   stat_b_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0] MID = (OFFSET_BINARY != 0) ? 16'h8000 : 16'h0000;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state, state_nx;
    logic [15:0]     mem_a [FIFO_DEPTH];
    logic [15:0]     mem_b [FIFO_DEPTH];
    logic [AW-1:0]   wr_a, rd_a, wr_b, rd_b;
    logic [31:0]     burst_len, pair_cnt;
    logic            push_a, push_b, pop, under, last, flush, accept, both;

    assign a_tready     = (state != IDLE) && (stat_a_level != LW'(FIFO_DEPTH));
    assign b_tready     = (state != IDLE) && (stat_b_level != LW'(FIFO_DEPTH));
    assign push_a       = a_tvalid && a_tready;
    assign push_b       = b_tvalid && b_tready;
    assign flush        = ctrl_stop || (state == IDLE);
    assign accept       = (state == IDLE) && ctrl_start && !ctrl_stop;
    assign both         = (stat_a_level != '0) && (stat_b_level != '0);
    assign pop          = (state == RUN) && !ctrl_stop && both;
    assign under        = (state == RUN) && !ctrl_stop && !both;
    assign last         = pop && (burst_len != 32'd0) && (pair_cnt + 32'd1 == burst_len);
    assign stat_running = (state == RUN);

    // state register
    always_ff @(posedge dac_clk_1x or negedge dac_rstn) begin
        if (!dac_rstn) state <= IDLE;
        else           state <= state_nx;
    end

    // next state: stop dominates, then start, priming threshold, burst end
    always_comb begin
        state_nx = state;
        if (ctrl_stop)
            state_nx = IDLE;
        else if (state == IDLE && ctrl_start)
            state_nx = PRIME;
        else if (state == PRIME && stat_a_level >= LW'(PRIME_LEVEL) && stat_b_level >= LW'(PRIME_LEVEL))
            state_nx = RUN;
        else if (last)
            state_nx = IDLE;
    end

    // sample storage; contents are don't-care once flushed
    always_ff @(posedge dac_clk_1x) begin
        if (push_a) mem_a[wr_a] <= a_tdata;
        if (push_b) mem_b[wr_b] <= b_tdata;
    end

    // FIFO pointers and occupancy, emptied whenever idle or stopping
    always_ff @(posedge dac_clk_1x or negedge dac_rstn) begin
        if (!dac_rstn || flush) begin
            wr_a <= '0; rd_a <= '0; stat_a_level <= '0;
            wr_b <= '0; rd_b <= '0; stat_b_level <= '0;
        end else begin
            wr_a <= wr_a + AW'(push_a);
            rd_a <= rd_a + AW'(pop);
            stat_a_level <= stat_a_level + LW'(push_a) - LW'(pop);
            wr_b <= wr_b + AW'(push_b);
            rd_b <= rd_b + AW'(pop);
            stat_b_level <= stat_b_level + LW'(push_b) - LW'(pop);
        end
    end

    // output registers: popped pair (MSB flipped via MID for offset binary) or midscale
    always_ff @(posedge dac_clk_1x or negedge dac_rstn) begin
        if (!dac_rstn) begin
            dac_da    <= MID;
            dac_db    <= MID;
            stat_done <= 1'b0;
        end else begin
            dac_da    <= pop ? (mem_a[rd_a] ^ MID) : MID;
            dac_db    <= pop ? (mem_b[rd_b] ^ MID) : MID;
            stat_done <= last;
        end
    end

    // burst bookkeeping and saturating underrun counter, reset on accepted start
    always_ff @(posedge dac_clk_1x or negedge dac_rstn) begin
        if (!dac_rstn) begin
            burst_len         <= '0;
            pair_cnt          <= '0;
            stat_underrun_cnt <= '0;
        end else if (accept) begin
            burst_len         <= ctrl_burst_len;
            pair_cnt          <= '0;
            stat_underrun_cnt <= '0;
        end else begin
            if (pop) pair_cnt <= pair_cnt + 32'd1;
            if (under && stat_underrun_cnt != 16'hFFFF) stat_underrun_cnt <= stat_underrun_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_redpi_dac_ctrl.sv
// tb_redpi_dac_ctrl: randomized scoreboard bench against a queue-based playback model
module tb_redpi_dac_ctrl;
    localparam int DEPTH = 8;
    localparam int PL    = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ctrl_start = 0, ctrl_stop = 0;
    logic [31:0] ctrl_burst_len = 0;
    logic [15:0] a_tdata = 0, b_tdata = 0;
    logic        a_tvalid = 0, b_tvalid = 0;
    logic        a_tready, b_tready, a_tready1, b_tready1;
    logic [15:0] dac_da, dac_db, dac_da1, dac_db1;
    logic        running, done, running1, done1;
    logic [15:0] und, und1;
    logic [3:0]  lvl_a, lvl_b, lvl_a1, lvl_b1;

    always #5 clk = ~clk;

    redpi_dac_ctrl #(.FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PL), .OFFSET_BINARY(0)) dut (
        .dac_clk_1x(clk), .dac_rstn(rst_n), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
        .ctrl_burst_len(ctrl_burst_len), .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready), .dac_da(dac_da), .dac_db(dac_db),
        .stat_running(running), .stat_done(done), .stat_underrun_cnt(und),
        .stat_a_level(lvl_a), .stat_b_level(lvl_b));

    redpi_dac_ctrl #(.FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PL), .OFFSET_BINARY(1)) dut_ob (
        .dac_clk_1x(clk), .dac_rstn(rst_n), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
        .ctrl_burst_len(ctrl_burst_len), .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready1),
        .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready1), .dac_da(dac_da1), .dac_db(dac_db1),
        .stat_running(running1), .stat_done(done1), .stat_underrun_cnt(und1),
        .stat_a_level(lvl_a1), .stat_b_level(lvl_b1));

    typedef struct {
        logic [15:0] da, db, und;
        logic        done, run, ra, rb;
        int          la, lb;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] qa[$], qb[$];
    int          m_state;
    logic [31:0] m_len, m_cnt;
    logic [15:0] m_und, oa, ob;
    logic        dn, pa, pb;
    int          total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: one transaction per clock, expressed with sample queues
    always @(posedge clk) begin
        exp_t e;
        oa = 16'h0; ob = 16'h0; dn = 1'b0;
        if (!rst_n) begin
            m_state = 0; qa.delete(); qb.delete(); m_und = 0; m_cnt = 0; m_len = 0;
        end else begin
            pa = a_tvalid && m_state != 0 && qa.size() < DEPTH;
            pb = b_tvalid && m_state != 0 && qb.size() < DEPTH;
            if (ctrl_stop) begin
                m_state = 0; qa.delete(); qb.delete();
            end else if (m_state == 0) begin
                qa.delete(); qb.delete();
                if (ctrl_start) begin m_state = 1; m_len = ctrl_burst_len; m_cnt = 0; m_und = 0; end
            end else begin
                if (m_state == 1 && qa.size() >= PL && qb.size() >= PL) m_state = 2;
                else if (m_state == 2) begin
                    if (qa.size() > 0 && qb.size() > 0) begin
                        oa = qa.pop_front(); ob = qb.pop_front(); m_cnt = m_cnt + 1;
                        if (m_len != 0 && m_cnt == m_len) begin m_state = 0; dn = 1'b1; end
                    end else if (m_und != 16'hFFFF) m_und = m_und + 1;
                end
                if (pa) qa.push_back(a_tdata);
                if (pb) qb.push_back(b_tdata);
            end
        end
        e.da = oa; e.db = ob; e.done = dn; e.run = (m_state == 2); e.und = m_und;
        e.la = qa.size(); e.lb = qb.size();
        e.ra = m_state != 0 && qa.size() < DEPTH; e.rb = m_state != 0 && qb.size() < DEPTH;
        exp_q.push_back(e);
    end

    // monitor: compare both instances shortly after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty got=0 exp=1");
        end else begin
            e = exp_q.pop_front();
            chk("da", 32'(dac_da), 32'(e.da));
            chk("db", 32'(dac_db), 32'(e.db));
            chk("da_ob", 32'(dac_da1), 32'(e.da ^ 16'h8000));
            chk("db_ob", 32'(dac_db1), 32'(e.db ^ 16'h8000));
            chk("done", 32'(done), 32'(e.done));
            chk("running", 32'(running), 32'(e.run));
            chk("underrun", 32'(und), 32'(e.und));
            chk("lvl_a", 32'(lvl_a), e.la);
            chk("lvl_b", 32'(lvl_b), e.lb);
            chk("a_tready", 32'(a_tready), 32'(e.ra));
            chk("b_tready", 32'(b_tready), 32'(e.rb));
        end
    end

    task automatic step(input logic st, input logic sp, input logic [31:0] bl,
                        input logic av, input logic [15:0] ad, input logic bv, input logic [15:0] bd);
        @(negedge clk);
        ctrl_start = st; ctrl_stop = sp; ctrl_burst_len = bl;
        a_tvalid = av; a_tdata = ad; b_tvalid = bv; b_tdata = bd;
    endtask

    task automatic rnd(input int pa_pct, input int pb_pct);
        step(0, 0, 0, $urandom_range(0, 99) < pa_pct, 16'($urandom),
             $urandom_range(0, 99) < pb_pct, 16'($urandom));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        // priming: A only stays in PRIME, then B completes it
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'($urandom), 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 16'($urandom));
        repeat (200) rnd(50, 50);
        step(0, 1, 0, 0, 0, 0, 0);
        // finite burst of three pairs from four offered
        step(1, 0, 3, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 16'(i), 1, 16'(-i));
        repeat (10) step(0, 0, 0, 0, 0, 0, 0);
        // skewed supply to provoke underrun with lockstep pairing
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'($urandom), 1, 16'($urandom));
        repeat (300) rnd(70, 25);
        step(0, 1, 0, 0, 0, 0, 0);
        // backpressure: fill A past capacity, then stream both continuously
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 16'($urandom), 0, 0);
        repeat (80) step(0, 0, 0, 1, 16'($urandom), 1, 16'($urandom));
        step(0, 1, 0, 0, 0, 0, 0);
        // simultaneous start and stop keeps the block idle; zero sample round trip
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 16'h1234, 1, 16'h5678);
        step(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'h0000, 1, 16'h0000);
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);
        // random control traffic
        repeat (3000) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1, 32'($urandom_range(0, 12)),
                 $urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 60, 16'($urandom));
        end
        // asynchronous reset while running with buffered data
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 16'($urandom), 1, 16'($urandom));
        repeat (2) step(0, 0, 0, 1, 16'($urandom), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_da", 32'(dac_da), 32'h0000);
        chk("rst_db_ob", 32'(dac_db1), 32'h8000);
        chk("rst_lvl_a", 32'(lvl_a), 32'd0);
        chk("rst_a_tready", 32'(a_tready), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
